mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 64-bit memory entries served.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port init  input  1  pulse requesting a zero-fill sweep of all entries.
REQ-005 SHALL have port init_busy  output  1  high while the sweep runs.
REQ-006 SHALL have port wr_req / wr_addr / wr_data  input  1/16/8  byte-write requester.
REQ-007 SHALL have port wr_gnt  output  1  write accepted this cycle.
REQ-008 SHALL have port rd_req  input  2  read requests, bit i = reader i.
REQ-009 SHALL have port rd_addr0 / rd_addr1  input  16/16  read addresses.
REQ-010 SHALL have port rd_gnt  output  2  read accepted this cycle, one-hot or zero.
REQ-011 SHALL have port rd_valid  output  2  read data valid, bit i = reader i.
REQ-012 SHALL have port rd_data  output  64  returned entry.
REQ-013 SHALL have port err_addr  output  1  pulse: granted access had address >= DEPTH.
REQ-014 SHALL have ports mem_wen / mem_writePtr / mem_readPtr / mem_inData  output  1/16/16/8  drive the memory.
REQ-015 SHALL have port mem_outData  input  64  registered memory output.

Function
REQ-016 SHALL run FSM states IDLE and INIT.
REQ-017 SHALL, in IDLE, grant at most one of {W, R0, R1} per cycle, combinationally from same-cycle requests.
REQ-018 SHALL arbitrate round-robin: the requester after the last granted has highest priority. After reset, priority order is W > R0 > R1.
REQ-019 SHALL hold a request until its grant. A requester that drops its request before being granted is not served.
REQ-020 SHALL, on a write grant with wr_addr < DEPTH, drive mem_wen=1, mem_writePtr=wr_addr and mem_inData=wr_data in the same cycle.
REQ-021 SHALL note that each memory write shifts one byte into the entry; eight writes fill an entry, and the arbiter does not count bytes.
REQ-022 SHALL, on a read grant to reader i with address < DEPTH, drive mem_wen=0 and mem_readPtr=rd_addri.
REQ-023 SHALL then assert rd_valid[i] for exactly one cycle, the next cycle, with rd_data=mem_outData (latency 1).
REQ-024 SHALL, on any grant with address >= DEPTH, hold mem_wen=0 and issue no memory access, and pulse err_addr the next cycle.
REQ-025 SHALL, for such an out-of-range read, still pulse rd_valid[i] with rd_data=0.
REQ-026 SHALL drive mem_wen=0 and mem_readPtr=0 and mem_writePtr=0 in idle cycles (no grant), and hold rd_data=0 when rd_valid=0.
REQ-027 SHALL enter INIT on init=1 in IDLE. init beats same-cycle requests, which receive no grant.
REQ-028 SHALL, in INIT, write 0x00 eight times per entry for entries 0..DEPTH-1, one write per cycle.
REQ-029 SHALL order the sweep using a 3-bit byte counter and an entry counter. The sweep takes DEPTH*8 cycles.
REQ-030 SHALL hold init_busy=1 and wr_gnt=rd_gnt=0 during INIT, and ignore init while in INIT.
REQ-031 SHALL return to IDLE the cycle after the last sweep write (entry DEPTH-1, byte 7), with init_busy=0 in that cycle.
REQ-032 SHALL let a read granted in the last IDLE cycle before INIT still complete rd_valid in the first INIT cycle.
REQ-033 SHALL reset the round-robin pointer to W after INIT.

Reset
REQ-034 SHALL, while reset=0, force the FSM to IDLE, clear the counters and the pointer to W, and drive all outputs 0.
REQ-035 SHALL treat reset=0 mid-sweep as abandoning the sweep. The memory is left partially cleared and no resume occurs.

Verification
REQ-036 SHALL cover: wr_req=1, rd_req=11 continuously -> grants cycle W, R0, R1, W...; rd_valid[0] one cycle after each R0 grant.
REQ-037 SHALL cover: 8 writes of 0x11..0x88 to addr 5, then R1 read addr 5 -> rd_data=0x1122334455667788 one cycle after grant.
REQ-038 SHALL cover: R0 read addr 64 (DEPTH=64) -> mem_wen=0; next cycle err_addr=1, rd_valid[0]=1, rd_data=0.
REQ-039 SHALL cover: init with wr_req=1 same cycle -> wr_gnt=0; init_busy high 512 cycles; afterwards a read of any entry returns 0.
REQ-040 SHALL cover: reset=0 at sweep cycle 100 -> outputs 0, IDLE; after release, wr_req is granted immediately.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter between one byte writer and two readers, with zero-fill sweep
module mem_arbiter #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  output logic        init_busy,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_gnt,
  input  logic [1:0]  rd_req,
  input  logic [15:0] rd_addr0,
  input  logic [15:0] rd_addr1,
  output logic [1:0]  rd_gnt,
  output logic [1:0]  rd_valid,
  output logic [63:0] rd_data,
  output logic        err_addr,
  output logic        mem_wen,
  output logic [15:0] mem_writePtr,
  output logic [15:0] mem_readPtr,
  output logic [7:0]  mem_inData,
  input  logic [63:0] mem_outData
);

  // Entry counter width; a single-entry memory still needs a 1-bit counter.
  localparam int unsigned ENT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // 17 bits so that DEPTH = 65536 still compares correctly against 16-bit addresses.
  localparam logic [16:0]      DEPTH_L    = 17'(DEPTH);
  localparam logic [ENT_W-1:0] LAST_ENTRY = ENT_W'(DEPTH - 1);

  // Requester indices; the priority pointer names the requester served first.
  localparam logic [1:0] P_W  = 2'd0;
  localparam logic [1:0] P_R0 = 2'd1;
  localparam logic [1:0] P_R1 = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_INIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       prio_q, prio_d;
  logic [2:0]       byte_q, byte_d;
  logic [ENT_W-1:0] entry_q, entry_d;
  logic [1:0]       rd_valid_q, rd_valid_d;
  logic             rd_oor_q, rd_oor_d;
  logic             err_q, err_d;

  logic [2:0]       req_vec;
  logic [2:0]       gnt_vec;
  logic             wr_in_range;
  logic             rd0_in_range;
  logic             rd1_in_range;
  logic             sweep_last;

  assign wr_in_range  = ({1'b0, wr_addr}  < DEPTH_L);
  assign rd0_in_range = ({1'b0, rd_addr0} < DEPTH_L);
  assign rd1_in_range = ({1'b0, rd_addr1} < DEPTH_L);

  // The sweep ends on byte 7 of the final entry.
  assign sweep_last = (state_q == S_INIT) && (byte_q == 3'd7) && (entry_q == LAST_ENTRY);

  // Round-robin pick among {W, R0, R1}; nothing is granted while sweeping or when init arrives.
  always_comb begin
    req_vec = {rd_req[1], rd_req[0], wr_req};
    gnt_vec = 3'b000;
    if (state_q == S_IDLE && !init) begin
      case (prio_q)
        P_R0: begin
          if      (req_vec[1]) gnt_vec = 3'b010;
          else if (req_vec[2]) gnt_vec = 3'b100;
          else if (req_vec[0]) gnt_vec = 3'b001;
        end
        P_R1: begin
          if      (req_vec[2]) gnt_vec = 3'b100;
          else if (req_vec[0]) gnt_vec = 3'b001;
          else if (req_vec[1]) gnt_vec = 3'b010;
        end
        default: begin
          if      (req_vec[0]) gnt_vec = 3'b001;
          else if (req_vec[1]) gnt_vec = 3'b010;
          else if (req_vec[2]) gnt_vec = 3'b100;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: init starts the sweep, the last sweep write returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (init) state_d = S_INIT;
      S_INIT: if (sweep_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: sweep writes in INIT, granted access in IDLE, everything low in reset.
  always_comb begin
    init_busy    = 1'b0;
    wr_gnt       = 1'b0;
    rd_gnt       = 2'b00;
    mem_wen      = 1'b0;
    mem_writePtr = 16'h0000;
    mem_readPtr  = 16'h0000;
    mem_inData   = 8'h00;
    rd_valid     = 2'b00;
    err_addr     = 1'b0;
    if (reset) begin
      rd_valid = rd_valid_q;
      err_addr = err_q;
      case (state_q)
        S_INIT: begin
          init_busy    = 1'b1;
          mem_wen      = 1'b1;
          mem_writePtr = 16'(entry_q);
        end
        default: begin
          wr_gnt = gnt_vec[0];
          rd_gnt = gnt_vec[2:1];
          if (gnt_vec[0] && wr_in_range) begin
            mem_wen      = 1'b1;
            mem_writePtr = wr_addr;
            mem_inData   = wr_data;
          end
          if (gnt_vec[1] && rd0_in_range) mem_readPtr = rd_addr0;
          if (gnt_vec[2] && rd1_in_range) mem_readPtr = rd_addr1;
        end
      endcase
    end
  end

  // Read return path: memory data only for an in-range read, zero otherwise.
  always_comb begin
    rd_data = 64'h0;
    if (reset && (rd_valid_q != 2'b00) && !rd_oor_q) rd_data = mem_outData;
  end

  // Next-cycle completion flags, priority pointer and sweep counters.
  always_comb begin
    rd_valid_d = gnt_vec[2:1];
    rd_oor_d   = (gnt_vec[1] && !rd0_in_range) || (gnt_vec[2] && !rd1_in_range);
    err_d      = (gnt_vec[0] && !wr_in_range) || rd_oor_d;

    prio_d = prio_q;
    if (state_q == S_INIT)  prio_d = P_W;
    else if (gnt_vec[0])    prio_d = P_R0;
    else if (gnt_vec[1])    prio_d = P_R1;
    else if (gnt_vec[2])    prio_d = P_W;

    byte_d  = 3'd0;
    entry_d = '0;
    if (state_q == S_INIT) begin
      byte_d  = byte_q + 3'd1;
      entry_d = entry_q;
      if (byte_q == 3'd7) begin
        entry_d = (entry_q == LAST_ENTRY) ? '0 : entry_q + ENT_W'(1);
      end
    end
  end

  // Datapath registers; reset abandons any sweep in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q     <= P_W;
      byte_q     <= 3'd0;
      entry_q    <= '0;
      rd_valid_q <= 2'b00;
      rd_oor_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      byte_q     <= byte_d;
      entry_q    <= entry_d;
      rd_valid_q <= rd_valid_d;
      rd_oor_q   <= rd_oor_d;
      err_q      <= err_d;
    end
  end

endmodule
